// File: rtl/imem_responder.sv
// Instruction memory for the cpu fetch port. Each accepted request is answered after WAIT_CYCLES wait states.
// The answer is a single-cycle valid strobe. A side port writes the program image.
module imem_responder #(
    parameter int          DEPTH       = 64,
    parameter int          ADDR_W      = 6,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] ERR_WORD    = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       pc,
    input  logic              req,
    output logic [31:0]       instruction,
    output logic              valid,
    output logic              err,
    output logic              busy,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              fault_q;
    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_now;
    logic              fault_now;

    // The range check uses the full word address, so high pc bits fault instead of wrapping.
    assign word_now  = pc[ADDR_W+1:2];
    assign fault_now = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(DEPTH));

    // NOTE: memory arrays get no reset; the boot loader writes the image, and a reset would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            fault_q     <= 1'b0;
            instruction <= '0;
            valid       <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // NOTE: strobes default low here, so each is high only in the cycle that a branch below raises it.
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req && !load_en) begin
                        addr_q  <= word_now;
                        fault_q <= fault_now;
                        cnt     <= 4'(WAIT_CYCLES);
                        busy    <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state       <= S_RESP;
                            valid       <= 1'b1;
                            err         <= fault_now;
                            instruction <= fault_now ? ERR_WORD : mem[word_now];
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    // The read samples the pre-edge memory contents, so a load on this same edge is not yet visible.
                    if (cnt == 4'd1) begin
                        state       <= S_RESP;
                        valid       <= 1'b1;
                        err         <= fault_q;
                        instruction <= fault_q ? ERR_WORD : mem[addr_q];
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
